// File: rtl/sbc_pkg.sv
// Shared definitions for the SRAM port: FSM state encoding and default
// access-strobe width.
package sbc_pkg;

  // Default SRAM strobe width in clk cycles (legal range 1..15).
  localparam int SRAM_WAIT_CYCLES_DEFAULT = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_SETUP = 3'd1,
    W_PULSE = 3'd2,
    W_HOLD  = 3'd3,
    R_SETUP = 3'd4,
    R_WAIT  = 3'd5,
    R_DONE  = 3'd6
  } sram_state_e;

  // Busy covers every state that drives an access.
  // R_DONE only presents the result, so it is not busy.
  function automatic logic state_is_busy(sram_state_e s);
    return !((s == IDLE) || (s == R_DONE));
  endfunction

endpackage

// File: rtl/sram_port_if.sv
// Client-side bus of the SRAM port.
//
// Handshake semantics:
// - A command is taken only when the port is idle with sram_req=1 and a
//   0->1 edge is seen on sram_write or sram_read.
// - Write wins when both edges arrive together.
// - While sram_busy=1, command edges are dropped, not queued.
// - A read result is offered with sram_valid=1 and held stable until the
//   client lowers sram_read.
// - sram_valid falls the cycle after sram_read is seen low.
interface sram_port_if;
  logic        sram_req;
  logic        sram_read;
  logic        sram_write;
  logic [15:0] sram_addr;
  logic [7:0]  sram_wdata;
  logic        sram_busy;
  logic        sram_valid;
  logic [7:0]  sram_rdata;

  modport master (
    output sram_req, sram_read, sram_write, sram_addr, sram_wdata,
    input  sram_busy, sram_valid, sram_rdata
  );

  modport slave (
    input  sram_req, sram_read, sram_write, sram_addr, sram_wdata,
    output sram_busy, sram_valid, sram_rdata
  );
endinterface

// File: rtl/sram_port_timer.sv
// Strobe-width counter.
// It loads the cycle count during a setup state, then counts down while the
// strobe is active. done_o flags the last strobe cycle.
module sram_port_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       done_o
);
  logic [3:0] cnt_q, cnt_d;

  // Load has priority over decrement; the counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != 4'd0))
      cnt_d = cnt_q - 4'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == 4'd0);
endmodule

// File: rtl/sram_port.sv
// Asynchronous SRAM access port.
// It turns client read/write command edges into timed ce/oe/we strobe
// sequences and arbitrates the SRAM pins with the i8080 through ram_bus_en.
module sram_port
  import sbc_pkg::*;
#(
  parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  sram_port_if.slave  bus,
  output logic [15:0] ram_a,
  output logic [7:0]  ram_dq_o,
  output logic        ram_dq_oe,
  input  logic [7:0]  ram_dq_i,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        ram_bus_en,
  output sram_state_e dbg_state_o
);
  localparam logic [3:0] STROBE_LOAD = 4'(WAIT_CYCLES - 1);

  sram_state_e state_q, state_d;
  logic        wr_prev_q, rd_prev_q;
  logic        wr_edge, rd_edge;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        bus_en_q, bus_en_d;
  logic        t_load, t_dec, t_done;
  logic        ce_n, oe_n, we_n, dq_oe;

  assign wr_edge = bus.sram_write & ~wr_prev_q;
  assign rd_edge = bus.sram_read & ~rd_prev_q;

  // The setup state loads the strobe width.
  // The strobe state counts it down.
  assign t_load = (state_q == W_SETUP) || (state_q == R_SETUP);
  assign t_dec  = (state_q == W_PULSE) || (state_q == R_WAIT);

  sram_port_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (t_load),
    .load_val_i (STROBE_LOAD),
    .dec_i      (t_dec),
    .done_o     (t_done)
  );

  // Next-state logic, including latching of the access and its result.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.sram_req && wr_edge) begin
          state_d = W_SETUP;
          addr_d  = bus.sram_addr;
          wdata_d = bus.sram_wdata;
        end else if (bus.sram_req && rd_edge) begin
          state_d = R_SETUP;
          addr_d  = bus.sram_addr;
        end
      end
      W_SETUP: state_d = W_PULSE;
      W_PULSE: if (t_done) state_d = W_HOLD;
      W_HOLD:  state_d = IDLE;
      R_SETUP: state_d = R_WAIT;
      R_WAIT: begin
        if (t_done) begin
          rdata_d = ram_dq_i;
          state_d = R_DONE;
        end
      end
      R_DONE:  if (!bus.sram_read) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The pins stay owned while the client asks or an access is still running.
  assign bus_en_d = bus.sram_req | (state_q != IDLE);

  // State, edge-flag, latch and bus-ownership registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_prev_q <= 1'b0;
      rd_prev_q <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      bus_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_prev_q <= bus.sram_write;
      rd_prev_q <= bus.sram_read;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      bus_en_q  <= bus_en_d;
    end
  end

  // Strobe decode per state.
  // we_n and oe_n are never active in the same state.
  always_comb begin
    ce_n  = 1'b1;
    oe_n  = 1'b1;
    we_n  = 1'b1;
    dq_oe = 1'b0;
    case (state_q)
      W_SETUP, W_HOLD: begin
        ce_n  = 1'b0;
        dq_oe = 1'b1;
      end
      W_PULSE: begin
        ce_n  = 1'b0;
        dq_oe = 1'b1;
        we_n  = 1'b0;
      end
      R_SETUP, R_WAIT: begin
        ce_n = 1'b0;
        oe_n = 1'b0;
      end
      default: ;
    endcase
  end

  // Releasing the bus forces every pin to its idle level.
  assign ram_bus_en = bus_en_q;
  assign ram_ce_n   = bus_en_q ? ce_n : 1'b1;
  assign ram_oe_n   = bus_en_q ? oe_n : 1'b1;
  assign ram_we_n   = bus_en_q ? we_n : 1'b1;
  assign ram_dq_oe  = bus_en_q & dq_oe;
  assign ram_a      = bus_en_q ? addr_q : 16'h0000;
  assign ram_dq_o   = bus_en_q ? wdata_q : 8'h00;

  assign bus.sram_busy  = state_is_busy(state_q);
  assign bus.sram_valid = (state_q == R_DONE);
  assign bus.sram_rdata = rdata_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_sram_port.sv
// Bench for sram_port.
// A cycle-level behavioural model derives every output from the cycle count
// since command acceptance. A behavioural async SRAM with an access time
// sits on the pins, and directed scenarios carry literal expectations.
module tb_sram_port;
  import sbc_pkg::*;

  localparam int W = 2;

  localparam int T_NONE    = 0;
  localparam int T_RST     = 1;
  localparam int T_WR      = 2;
  localparam int T_RD      = 3;
  localparam int T_BOTH    = 4;
  localparam int T_REQDROP = 5;
  localparam int T_NOREQ   = 6;
  localparam int T_RSTMID  = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_port_if bus ();

  logic [15:0] ram_a;
  logic [7:0]  ram_dq_o, ram_dq_i;
  logic        ram_dq_oe, ram_ce_n, ram_oe_n, ram_we_n, ram_bus_en;
  sram_state_e dbg_state;

  sram_port #(.WAIT_CYCLES(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ram_a       (ram_a),
    .ram_dq_o    (ram_dq_o),
    .ram_dq_oe   (ram_dq_oe),
    .ram_dq_i    (ram_dq_i),
    .ram_ce_n    (ram_ce_n),
    .ram_oe_n    (ram_oe_n),
    .ram_we_n    (ram_we_n),
    .ram_bus_en  (ram_bus_en),
    .dbg_state_o (dbg_state)
  );

  // ---------------- behavioural SRAM ----------------
  // Read data is only valid after oe has been low for W+1 cycles.
  // Before that the pins carry 0xEE.
  logic [7:0] mem [logic [15:0]];
  logic       rd_override = 1'b0;
  int         oe_cnt = 0;
  logic [7:0] sram_data = 8'h00;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (rd_override && (a == 16'h1234)) return 8'h5A;
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8];
  endfunction

  always @(negedge clk) begin
    if (ram_we_n === 1'b0 && ram_ce_n === 1'b0) mem[ram_a] = ram_dq_o;
    if (ram_oe_n === 1'b0 && ram_ce_n === 1'b0) oe_cnt = oe_cnt + 1;
    else oe_cnt = 0;
    sram_data = mem_rd(ram_a);
  end

  assign ram_dq_i = (ram_oe_n === 1'b0 && ram_ce_n === 1'b0 && oe_cnt >= W + 1)
                    ? sram_data : 8'hEE;

  // ---------------- reference model ----------------
  // m_kind: 0 idle, 1 write, 2 read.
  // m_k: cycles since the accept cycle.
  int          cyc = 0;
  logic        started = 1'b0;
  int          m_kind = 0;
  int          m_k = 0;
  logic        m_prev_wr = 1'b0, m_prev_rd = 1'b0, m_bus_en = 1'b0;
  logic [15:0] m_addr = 16'h0000;
  logic [7:0]  m_wdata = 8'h00, m_rdata = 8'h00;
  logic        m_wr_edge, m_rd_edge;

  always @(posedge clk) begin
    started = 1'b1;
    cyc = cyc + 1;
    m_wr_edge = bus.sram_write && !m_prev_wr;
    m_rd_edge = bus.sram_read && !m_prev_rd;
    if (rst) begin
      m_kind = 0; m_k = 0; m_prev_wr = 1'b0; m_prev_rd = 1'b0;
      m_bus_en = 1'b0; m_addr = 16'h0000; m_wdata = 8'h00; m_rdata = 8'h00;
    end else begin
      m_bus_en = bus.sram_req || (m_kind != 0);
      case (m_kind)
        0: begin
          if (bus.sram_req && m_wr_edge) begin
            m_kind = 1; m_k = 1; m_addr = bus.sram_addr; m_wdata = bus.sram_wdata;
          end else if (bus.sram_req && m_rd_edge) begin
            m_kind = 2; m_k = 1; m_addr = bus.sram_addr;
          end
        end
        1: begin
          if (m_k == W + 2) begin m_kind = 0; m_k = 0; end
          else m_k = m_k + 1;
        end
        default: begin
          if (m_k <= W) m_k = m_k + 1;
          else if (m_k == W + 1) begin m_rdata = mem_rd(m_addr); m_k = W + 2; end
          else if (!bus.sram_read) begin m_kind = 0; m_k = 0; end
        end
      endcase
      m_prev_wr = bus.sram_write;
      m_prev_rd = bus.sram_read;
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int test_id = T_RST;
  int t0 = 0;
  int rel;
  int lit_we_low;
  logic [7:0] lit_busy;

  logic e_busy, e_valid, e_ce_n, e_oe_n, e_we_n, e_dq_oe;
  logic [15:0] e_a;
  logic [7:0]  e_dq_o;
  int          e_state;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      e_busy  = (m_kind == 1) || (m_kind == 2 && m_k <= W + 1);
      e_valid = (m_kind == 2) && (m_k >= W + 2);
      e_ce_n  = !(m_bus_en && e_busy);
      e_oe_n  = !(m_bus_en && m_kind == 2 && m_k <= W + 1);
      e_we_n  = !(m_bus_en && m_kind == 1 && m_k >= 2 && m_k <= W + 1);
      e_dq_oe = m_bus_en && (m_kind == 1);
      e_a     = m_bus_en ? m_addr : 16'h0000;
      e_dq_o  = m_bus_en ? m_wdata : 8'h00;
      if (m_kind == 0) e_state = int'(IDLE);
      else if (m_kind == 1)
        e_state = (m_k == 1) ? int'(W_SETUP) : (m_k <= W + 1) ? int'(W_PULSE) : int'(W_HOLD);
      else
        e_state = (m_k == 1) ? int'(R_SETUP) : (m_k <= W + 1) ? int'(R_WAIT) : int'(R_DONE);

      chk("busy", bus.sram_busy, e_busy);
      chk("valid", bus.sram_valid, e_valid);
      chk("rdata", bus.sram_rdata, m_rdata);
      chk("ce_n", ram_ce_n, e_ce_n);
      chk("oe_n", ram_oe_n, e_oe_n);
      chk("we_n", ram_we_n, e_we_n);
      chk("dq_oe", ram_dq_oe, e_dq_oe);
      chk("ram_a", ram_a, e_a);
      chk("dq_o", ram_dq_o, e_dq_o);
      chk("bus_en", ram_bus_en, m_bus_en);
      chk("state", 32'(dbg_state), e_state);
      chk("we_oe_overlap", ram_we_n | ram_oe_n, 1'b1);
      chk("dq_drive_while_oe", ram_dq_oe & ~ram_oe_n, 1'b0);

      rel = cyc - t0;
      case (test_id)
        T_RST: begin
          chk("rst_busy", bus.sram_busy, 1'b0);
          chk("rst_valid", bus.sram_valid, 1'b0);
          chk("rst_rdata", bus.sram_rdata, 8'h00);
          chk("rst_strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_dq_oe}, 4'b1110);
          chk("rst_ram_a", ram_a, 16'h0000);
          chk("rst_dq_o", ram_dq_o, 8'h00);
          chk("rst_bus_en", ram_bus_en, 1'b0);
        end
        T_WR: begin
          if (rel == 1) begin lit_we_low = 0; lit_busy = 8'h00; end
          if (rel >= 1 && rel <= 6) begin
            if (ram_we_n === 1'b0) lit_we_low = lit_we_low + 1;
            lit_busy[rel] = bus.sram_busy;
          end
          if (rel == 2) begin
            chk("wr_ram_a", ram_a, 16'h1234);
            chk("wr_dq_o", ram_dq_o, 8'hA5);
          end
          if (rel == 6) begin
            chk("wr_we_low_cycles", lit_we_low, 2);
            chk("wr_busy_cycles", lit_busy, 8'h1E);
            chk("wr_mem", mem_rd(16'h1234), 8'hA5);
          end
        end
        T_RD: begin
          if (rel == 3) chk("rd_valid_early", bus.sram_valid, 1'b0);
          if (rel >= 4 && rel <= 7) begin
            chk("rd_valid", bus.sram_valid, 1'b1);
            chk("rd_rdata", bus.sram_rdata, 8'h5A);
            chk("rd_busy", bus.sram_busy, 1'b0);
          end
          if (rel == 6) chk("rd_no_new_access", ram_ce_n, 1'b1);
          if (rel == 8) begin
            chk("rd_valid_drop", bus.sram_valid, 1'b0);
            chk("rd_rdata_hold", bus.sram_rdata, 8'h5A);
          end
        end
        T_BOTH: begin
          if (rel == 1) chk("both_write_wins", 32'(dbg_state), 32'(W_SETUP));
          if (rel == 5) chk("both_idle", 32'(dbg_state), 32'(IDLE));
          if (rel == 7) begin
            chk("both_no_read", bus.sram_valid, 1'b0);
            chk("both_state", 32'(dbg_state), 32'(IDLE));
            chk("both_mem", mem_rd(16'h0042), 8'h3C);
            chk("both_rdata_kept", bus.sram_rdata, 8'h5A);
          end
        end
        T_REQDROP: begin
          if (rel == 1) lit_we_low = 0;
          if (rel >= 1 && rel <= 7 && ram_we_n === 1'b0) lit_we_low = lit_we_low + 1;
          if (rel == 5) begin
            chk("drop_bus_en_held", ram_bus_en, 1'b1);
            chk("drop_idle", 32'(dbg_state), 32'(IDLE));
          end
          if (rel == 6) begin
            chk("drop_bus_en_off", ram_bus_en, 1'b0);
            chk("drop_ram_a", ram_a, 16'h0000);
            chk("drop_pins", {ram_ce_n, ram_oe_n, ram_we_n, ram_dq_oe}, 4'b1110);
          end
          if (rel == 7) begin
            chk("drop_we_low_cycles", lit_we_low, 2);
            chk("drop_mem", mem_rd(16'hBEEF), 8'h77);
          end
        end
        T_NOREQ: begin
          if (rel >= 1 && rel <= 3) begin
            chk("noreq_busy", bus.sram_busy, 1'b0);
            chk("noreq_ce_n", ram_ce_n, 1'b1);
          end
          if (rel == 3) chk("noreq_mem", mem_rd(16'h5555), 8'h00);
        end
        T_RSTMID: begin
          if (rel == 2) begin
            chk("rstmid_in_wait_oe", ram_oe_n, 1'b0);
            chk("rstmid_in_wait_busy", bus.sram_busy, 1'b1);
          end
          if (rel == 3) begin
            chk("rstmid_ce_oe", {ram_ce_n, ram_oe_n}, 2'b11);
            chk("rstmid_busy", bus.sram_busy, 1'b0);
            chk("rstmid_valid", bus.sram_valid, 1'b0);
            chk("rstmid_bus_en", ram_bus_en, 1'b0);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- driver ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.sram_req = 1'b0; bus.sram_read = 1'b0; bus.sram_write = 1'b0;
    bus.sram_addr = 16'h0000; bus.sram_wdata = 8'h00;
    rst = 1'b1;
    test_id = T_RST;
    repeat (3) next_cycle();
    next_cycle();
    rst = 1'b0; test_id = T_NONE; bus.sram_req = 1'b1;
    repeat (2) next_cycle();

    // write 0xA5 to 0x1234 with a one-cycle pulse, inputs scrambled after
    bus.sram_addr = 16'h1234; bus.sram_wdata = 8'hA5; bus.sram_write = 1'b1;
    t0 = cyc; test_id = T_WR;
    next_cycle();
    bus.sram_write = 1'b0; bus.sram_addr = 16'hFFFF; bus.sram_wdata = 8'h00;
    repeat (6) next_cycle();

    // read 0x1234 (SRAM returns 0x5A), held 3 extra cycles then dropped
    rd_override = 1'b1;
    bus.sram_addr = 16'h1234; bus.sram_read = 1'b1;
    t0 = cyc; test_id = T_RD;
    next_cycle();
    bus.sram_addr = 16'h0000;
    repeat (6) next_cycle();
    bus.sram_read = 1'b0;
    repeat (2) next_cycle();

    // simultaneous edges, then a read rise while busy
    bus.sram_addr = 16'h0042; bus.sram_wdata = 8'h3C;
    bus.sram_write = 1'b1; bus.sram_read = 1'b1;
    t0 = cyc; test_id = T_BOTH;
    next_cycle();
    bus.sram_write = 1'b0; bus.sram_read = 1'b0;
    next_cycle();
    bus.sram_read = 1'b1;
    next_cycle();
    bus.sram_read = 1'b0;
    repeat (5) next_cycle();

    // request dropped during the write pulse
    bus.sram_addr = 16'hBEEF; bus.sram_wdata = 8'h77; bus.sram_write = 1'b1;
    t0 = cyc; test_id = T_REQDROP;
    next_cycle();
    bus.sram_write = 1'b0;
    next_cycle();
    bus.sram_req = 1'b0;
    repeat (6) next_cycle();

    // command edge without request
    bus.sram_addr = 16'h5555; bus.sram_wdata = 8'h11; bus.sram_write = 1'b1;
    t0 = cyc; test_id = T_NOREQ;
    next_cycle();
    bus.sram_write = 1'b0;
    repeat (3) next_cycle();

    // reset during R_WAIT
    bus.sram_req = 1'b1;
    next_cycle();
    bus.sram_addr = 16'h1234; bus.sram_read = 1'b1;
    t0 = cyc; test_id = T_RSTMID;
    repeat (2) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; bus.sram_read = 1'b0;
    repeat (3) next_cycle();

    test_id = T_NONE;
    repeat (2) next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
